sprite_line_engine: RTL
=======================

// Module: sprite_line_engine
// PURPOSE
//  Scanline-buffered successor to the single-pass sprite comparator. Hosts the same 64-byte sprite RAM
//  behind the 8/16/32-bit host port. In each horizontal blank, an FSM evaluates all MAX_SPRITES
//  descriptors for the next line and fetches up to SLOTS bitmap rows into shadow slots. During active
//  video, it shifts pixels out with fixed priority, a sprite ID, an overflow flag and optional collision.
// PARAMETERS
//  MAX_SPRITES  8    descriptors at RAM[4i..4i+3] = {x, y, bmp_off, size}; MAX_SPRITES*4 <= 48
//  SLOTS        4    sprites displayable per scanline (1..MAX_SPRITES)
//  H_ACTIVE     640  first blank pixel_x; evaluation starts when pix_x == H_ACTIVE
//  H_TOTAL      800  line length; slot commit at pix_x == H_TOTAL-1
//  V_TOTAL      525  frame height; target line wraps to 0 after V_TOTAL-1
// PORTS
//  clk             in   1   single clock
//  rst             in   1   reset: one clock; reset is synchronous and active-high
//  video_active    in   1   display enable
//  pix_x           in   10  current pixel column
//  pix_y           in   10  current pixel row
//  vsync           in   1   frame sync (collision flag snapshot, see CONFIGURATION)
//  address         in   6   host byte address; 63 = STATUS register
//  data_in         in   32  host write data, little-endian bytes
//  data_write_n    in   2   00 byte, 01 half, 10 word, 11 idle
//  data_read_n     in   2   encoded as data_write_n
//  data_out        out  32  combinational read data, zero-extended
//  data_ready      out  1   = (data_read_n != 2'b11)
//  user_interrupt  out  1   collision IRQ (0 when the feature is compiled out)
//  sprite_pixel_on out  1   registered sprite pixel
//  sprite_id       out  $clog2(MAX_SPRITES)  index of the winning sprite; 0 when no pixel
// BEHAVIOUR
//  Reset: RAM all 0; all slots/shadows invalid; FSM IDLE; status 0; pixel_on, id and IRQ outputs 0.
//  Host writes
//   - Semantics match the previous engine: 16-bit writes need addr<62, 32-bit writes need addr<60,
//     otherwise the write is dropped.
//   - Any write to addr 63 clears STATUS. Reads of 63 return {6'b0, collision, overflow}.
//  Descriptor fields
//   - Width w = size[7:4]+1 and height h = size[3:0]+1 (1..16).
//   - Row stride = 1 byte if w<=8, else 2 bytes. Row r starts at bmp_off + r*stride.
//   - Bit k of the row word (LSB first) is column k.
//  FSM: IDLE -> EVAL -> FETCH0 -> [FETCH1] -> EVAL ... -> DONE -> IDLE
//   - IDLE: wait for pix_x == H_ACTIVE. Then T = (pix_y==V_TOTAL-1) ? 0 : pix_y+1; i = 0; clear shadows.
//   - EVAL (1 cycle per sprite): hit if y <= T < y+h (11-bit compare, no wrap).
//     - hit with a free shadow slot -> FETCH0.
//     - hit with no free slot -> set overflow (sticky) and skip the sprite.
//     - no hit -> i++.
//     - after i == MAX_SPRITES-1 -> DONE.
//   - FETCH0/FETCH1: read row bytes; any byte address >= 63 reads 0. Load the slot with {x, w, row}
//     and set it valid. FETCH1 only when w > 8.
//   - Worst case 3*MAX_SPRITES+2 cycles, which must fit in H_TOTAL-H_ACTIVE.
//   - DONE: hold until commit.
//   - Commit at pix_x == H_TOTAL-1: shadow -> active slots, FSM -> IDLE. A commit arriving in EVAL or
//     FETCH also aborts the scan; the partial shadow set is committed.
//  Pixel path (1-cycle latency from pix_x)
//   - Slot s is lit when valid && video_active && x <= pix_x < x+w && row[pix_x-x].
//   - Lowest slot index wins, i.e. the lowest sprite index.
//   - sprite_pixel_on and sprite_id are registered on the next clk.
//  Host writes mid-line take effect on the next evaluation only; committed slots are unaffected.
//  rst asserted mid-scan: immediate return to reset state; no partial commit.
// CONFIGURATION
//  SPRITE_COLLISION_EN defined:
//   - Two or more lit slots in one cycle set STATUS.collision (sticky).
//   - user_interrupt = collision, held until the host writes addr 63.
//   - vsync has no further effect.
//  Undefined: the collision bit reads 0 and user_interrupt is tied 0; no collision logic is built.
// TESTING
//  1. Sprite 0 descriptor = {x=10, y=5, off=32, size=0x70} and RAM[32]=0xA5.
//     -> On line 5, pixel_on=1 at pix_x 10,12,15,17 (seen one clk later); 0 on all other lines.
//  2. 16-wide sprite with size=0xF0, RAM[off]=0x01, RAM[off+1]=0x80.
//     -> Lit at columns x and x+15 only; both fetch cycles are observed in FSM.
//  3. SLOTS=4 with 6 sprites on line 20.
//     -> Sprites 0-3 drawn; 4 and 5 absent; STATUS reads 0x01. A write to 63 clears it to 0x00.
//  4. Sprites 1 and 3 overlap at (50,50).
//     -> sprite_id=1. With SPRITE_COLLISION_EN: user_interrupt=1 and STATUS=0x02 until cleared.
//  5. Sprite at y=0 while pix_y=V_TOTAL-1.
//     -> Drawn on line 0 (wrap). Sprite with off=62, w=16: the second byte reads 0, so the upper half is blank.
//  6. rst pulsed during FETCH0.
//     -> All outputs 0 next clk; no slots committed; normal drawing resumes the next line after release.

Source files
------------

// File: rtl/sprite_line_engine_if.sv
// Host byte-addressed bus into the sprite RAM and STATUS register.
// The host drives a transfer by setting a non-idle size code (2'b11 = idle) for one clock.
interface sprite_line_engine_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/sprite_line_engine.sv
// Scanline sprite engine: evaluates descriptors during h-blank into shadow slots, draws committed slots.
// Optional collision detection/IRQ is built only when SPRITE_COLLISION_EN is defined.
module sprite_line_engine #(
    parameter int MAX_SPRITES = 8,
    parameter int SLOTS       = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           video_active,
    input  logic [9:0]                     pix_x,
    input  logic [9:0]                     pix_y,
    input  logic                           vsync,
    sprite_line_engine_if.slave            host,
    output logic                           user_interrupt,
    output logic                           sprite_pixel_on,
    output logic [$clog2(MAX_SPRITES)-1:0] sprite_id,
    output logic [2:0]                     fsm_state_o
);
    localparam int IW = $clog2(MAX_SPRITES);
    localparam int SW = $clog2(SLOTS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVAL   = 3'd1,
        S_FETCH0 = 3'd2,
        S_FETCH1 = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] sh_cnt_q, sh_cnt_d;
    logic [9:0]    target_q, target_d;
    logic [8:0]    fetch_addr_q, fetch_addr_d;
    logic [7:0]    cur_x_q, cur_x_d;
    logic [4:0]    cur_w_q, cur_w_d;

    logic [7:0]    ram_q [64];
    logic          ovf_q;
    logic          coll_bit;

    logic [SLOTS-1:0] sh_v_q, act_v_q;
    logic [7:0]       sh_x_q   [SLOTS];
    logic [7:0]       act_x_q  [SLOTS];
    logic [4:0]       sh_w_q   [SLOTS];
    logic [4:0]       act_w_q  [SLOTS];
    logic [15:0]      sh_row_q [SLOTS];
    logic [15:0]      act_row_q[SLOTS];
    logic [IW-1:0]    sh_id_q  [SLOTS];
    logic [IW-1:0]    act_id_q [SLOTS];

    logic [5:0]  desc_base;
    logic [7:0]  d_x, d_y, d_off, d_size;
    logic [4:0]  d_w, d_h;
    logic [10:0] y_ext, t_ext, y_end;
    logic [3:0]  d_row;
    logic [8:0]  d_fetch;
    logic        hit;

    always_comb begin
        desc_base = 6'(idx_q) << 2;
        d_x    = ram_q[desc_base];
        d_y    = ram_q[desc_base + 6'd1];
        d_off  = ram_q[desc_base + 6'd2];
        d_size = ram_q[desc_base + 6'd3];
        d_w    = {1'b0, d_size[7:4]} + 5'd1;
        d_h    = {1'b0, d_size[3:0]} + 5'd1;
        y_ext  = {3'b000, d_y};
        t_ext  = {1'b0, target_q};
        y_end  = y_ext + {6'b0, d_h};
        hit    = (y_ext <= t_ext) && (t_ext < y_end);
        d_row  = t_ext[3:0] - y_ext[3:0];
        // Rows wider than 8 pixels occupy two consecutive bytes.
        d_fetch = {1'b0, d_off} + ((d_w > 5'd8) ? {4'b0, d_row, 1'b0} : {5'b0, d_row});
    end

    logic [8:0] fetch_hi_addr;
    logic [7:0] fb_lo, fb_hi;

    always_comb begin
        fetch_hi_addr = fetch_addr_q + 9'd1;
        fb_lo = (fetch_addr_q  >= 9'd63) ? 8'h00 : ram_q[fetch_addr_q[5:0]];
        fb_hi = (fetch_hi_addr >= 9'd63) ? 8'h00 : ram_q[fetch_hi_addr[5:0]];
    end

    logic start, load_lo, load_hi, slot_done, set_ovf, commit, advance;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sh_cnt_d     = sh_cnt_q;
        target_d     = target_q;
        fetch_addr_d = fetch_addr_q;
        cur_x_d      = cur_x_q;
        cur_w_d      = cur_w_q;
        start        = 1'b0;
        load_lo      = 1'b0;
        load_hi      = 1'b0;
        slot_done    = 1'b0;
        set_ovf      = 1'b0;
        advance      = 1'b0;
        commit       = (pix_x == 10'(H_TOTAL - 1));
        // Commit wins over any scan step, so an unfinished scan is cut short here.
        if (commit) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pix_x == 10'(H_ACTIVE)) begin
                        start    = 1'b1;
                        idx_d    = '0;
                        sh_cnt_d = '0;
                        target_d = (pix_y == 10'(V_TOTAL - 1)) ? 10'd0 : pix_y + 10'd1;
                        state_d  = S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (hit && (sh_cnt_q < SW'(SLOTS))) begin
                        cur_x_d      = d_x;
                        cur_w_d      = d_w;
                        fetch_addr_d = d_fetch;
                        state_d      = S_FETCH0;
                    end else begin
                        set_ovf = hit;
                        advance = 1'b1;
                    end
                end
                S_FETCH0: begin
                    load_lo = 1'b1;
                    if (cur_w_q > 5'd8) begin
                        state_d = S_FETCH1;
                    end else begin
                        slot_done = 1'b1;
                        advance   = 1'b1;
                    end
                end
                S_FETCH1: begin
                    load_hi   = 1'b1;
                    slot_done = 1'b1;
                    advance   = 1'b1;
                end
                default: ;
            endcase
            if (slot_done) sh_cnt_d = sh_cnt_q + SW'(1);
            if (advance) begin
                if (idx_q == IW'(MAX_SPRITES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_EVAL;
                end
            end
        end
    end

    logic [SLOTS-1:0] lit;
    logic             any_lit;
    logic [IW-1:0]    win_id;
    logic [10:0]      dx;

    always_comb begin
        lit     = '0;
        any_lit = 1'b0;
        win_id  = '0;
        dx      = '0;
        for (int s = 0; s < SLOTS; s++) begin
            dx     = {1'b0, pix_x} - {3'b000, act_x_q[s]};
            lit[s] = act_v_q[s] && video_active && (pix_x >= {2'b00, act_x_q[s]}) &&
                     (dx < {6'b0, act_w_q[s]}) && act_row_q[s][dx[3:0]];
        end
        // Walk downward so the lowest lit slot is the one left standing.
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (lit[s]) begin
                any_lit = 1'b1;
                win_id  = act_id_q[s];
            end
        end
    end

    logic [7:0] rd_b [4];
    logic [6:0] rd_a;

    always_comb begin
        rd_a = '0;
        for (int k = 0; k < 4; k++) begin
            rd_a    = {1'b0, host.address} + 7'(k);
            rd_b[k] = (rd_a >= 7'd63) ? 8'h00 : ram_q[rd_a[5:0]];
        end
        host.data_out = '0;
        if (host.data_read_n != 2'b11) begin
            if (host.address == 6'd63) begin
                host.data_out = {24'h0, 6'h0, coll_bit, ovf_q};
            end else begin
                case (host.data_read_n)
                    2'b00:   host.data_out = {24'h0, rd_b[0]};
                    2'b01:   host.data_out = {16'h0, rd_b[1], rd_b[0]};
                    default: host.data_out = {rd_b[3], rd_b[2], rd_b[1], rd_b[0]};
                endcase
            end
        end
    end

    assign host.data_ready = (host.data_read_n != 2'b11);
    assign fsm_state_o     = state_q;

    logic host_wr, clr_status;
    assign host_wr    = (host.data_write_n != 2'b11);
    assign clr_status = host_wr && (host.address == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            sh_cnt_q        <= '0;
            target_q        <= '0;
            fetch_addr_q    <= '0;
            cur_x_q         <= '0;
            cur_w_q         <= '0;
            ovf_q           <= 1'b0;
            sh_v_q          <= '0;
            act_v_q         <= '0;
            sprite_pixel_on <= 1'b0;
            sprite_id       <= '0;
            for (int a = 0; a < 64; a++) ram_q[a] <= 8'h00;
            for (int s = 0; s < SLOTS; s++) begin
                sh_x_q[s]    <= '0;
                sh_w_q[s]    <= '0;
                sh_row_q[s]  <= '0;
                sh_id_q[s]   <= '0;
                act_x_q[s]   <= '0;
                act_w_q[s]   <= '0;
                act_row_q[s] <= '0;
                act_id_q[s]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sh_cnt_q     <= sh_cnt_d;
            target_q     <= target_d;
            fetch_addr_q <= fetch_addr_d;
            cur_x_q      <= cur_x_d;
            cur_w_q      <= cur_w_d;

            if (host_wr && !clr_status) begin
                case (host.data_write_n)
                    2'b00: ram_q[host.address] <= host.data_in[7:0];
                    2'b01: begin
                        if (host.address < 6'd62) begin
                            ram_q[host.address]        <= host.data_in[7:0];
                            ram_q[host.address + 6'd1] <= host.data_in[15:8];
                        end
                    end
                    default: begin
                        if (host.address < 6'd60) begin
                            ram_q[host.address]        <= host.data_in[7:0];
                            ram_q[host.address + 6'd1] <= host.data_in[15:8];
                            ram_q[host.address + 6'd2] <= host.data_in[23:16];
                            ram_q[host.address + 6'd3] <= host.data_in[31:24];
                        end
                    end
                endcase
            end

            if (set_ovf)         ovf_q <= 1'b1;
            else if (clr_status) ovf_q <= 1'b0;

            if (start) sh_v_q <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                if (SW'(s) == sh_cnt_q) begin
                    if (load_lo) begin
                        sh_x_q[s]   <= cur_x_q;
                        sh_w_q[s]   <= cur_w_q;
                        sh_id_q[s]  <= idx_q;
                        sh_row_q[s] <= {8'h00, fb_lo};
                    end
                    if (load_hi)   sh_row_q[s][15:8] <= fb_hi;
                    if (slot_done) sh_v_q[s] <= 1'b1;
                end
            end

            if (commit) begin
                act_v_q <= sh_v_q;
                for (int s = 0; s < SLOTS; s++) begin
                    act_x_q[s]   <= sh_x_q[s];
                    act_w_q[s]   <= sh_w_q[s];
                    act_row_q[s] <= sh_row_q[s];
                    act_id_q[s]  <= sh_id_q[s];
                end
            end

            sprite_pixel_on <= any_lit;
            sprite_id       <= win_id;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic coll_q;
    logic multi_lit;
    assign multi_lit = ((lit & (lit - SLOTS'(1))) != '0);

    always_ff @(posedge clk) begin
        if (rst)             coll_q <= 1'b0;
        else if (multi_lit)  coll_q <= 1'b1;
        else if (clr_status) coll_q <= 1'b0;
    end

    assign coll_bit       = coll_q;
    assign user_interrupt = coll_q;
`else
    assign coll_bit       = 1'b0;
    assign user_interrupt = 1'b0;
`endif

    // vsync plays no role in this engine; kept on the port list for pin compatibility.
    logic unused_vsync;
    assign unused_vsync = vsync;
endmodule
